// File: rtl/adc_spi_responder.sv
// +--------------------------------------------------------------------------+
// | adc_spi_responder                                                        |
// | Emulates an 8-channel 12-bit serial ADC behind an SPI controller.        |
// | Optional macro ADC_RESP_TESTPAT_EN: A0 selects a {ch, 9'h0A5} pattern.   |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
`default_nettype none

module adc_spi_responder #(
  parameter int         W_LENGTH    = 13,
  parameter int         SYNC_STAGES = 2,
  parameter logic [2:0] CH_RST      = 3'd0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                conv_in,
  input  logic                sclk_in,
  input  logic                sdi_in,
  output logic                sdo_out,
  input  logic [2:0]          ch_addr_in,
  input  logic [11:0]         ch_data_in,
  input  logic                ch_we_in,
  output logic [W_LENGTH-1:0] ctrl_out,
  output logic [2:0]          ch_out,
  output logic                frame_done,
  output logic                frame_err
);

  localparam int CNT_W = $clog2(W_LENGTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Each synchroniser stage carries {conv, sclk, sdi}; conv idles high.
  localparam logic [2:0] SYNC_RST = 3'b100;

  state_t                          state_q, state_d;
  logic [SYNC_STAGES-1:0][2:0]     sync_q, sync_d;
  logic [2:0]                      prev_q, prev_d;
  logic [W_LENGTH-1:0]             shift_tx_q, shift_tx_d;
  logic [W_LENGTH-1:0]             shift_rx_q, shift_rx_d;
  logic [CNT_W-1:0]                cnt_q, cnt_d;
  logic                            sdo_q, sdo_d;
  logic [W_LENGTH-1:0]             ctrl_q, ctrl_d;
  logic [2:0]                      ch_q, ch_d;
  logic                            done_q, done_d;
  logic                            err_q, err_d;
  logic [7:0][11:0]                bank_q, bank_d;

  logic                            conv_s, sclk_s, sdi_s;
  logic                            conv_fall, conv_rise, sclk_rise, sclk_fall;
  logic [11:0]                     sample;
  logic [W_LENGTH-1:0]             rx_next;

  assign conv_s    = sync_q[SYNC_STAGES-1][2];
  assign sclk_s    = sync_q[SYNC_STAGES-1][1];
  assign sdi_s     = sync_q[SYNC_STAGES-1][0];
  assign conv_fall = prev_q[2] & ~conv_s;
  assign conv_rise = ~prev_q[2] & conv_s;
  assign sclk_rise = ~prev_q[1] & sclk_s;
  assign sclk_fall = prev_q[1] & ~sclk_s;
  assign rx_next   = {shift_rx_q[W_LENGTH-2:0], sdi_s};

`ifdef ADC_RESP_TESTPAT_EN
  assign sample = ctrl_q[12] ? {ch_q, 9'h0A5} : bank_q[ch_q];
`else
  assign sample = bank_q[ch_q];
`endif

  always_comb begin
    state_d    = state_q;
    sync_d     = {sync_q[SYNC_STAGES-2:0], {conv_in, sclk_in, sdi_in}};
    prev_d     = {conv_s, sclk_s, sdi_s};
    shift_tx_d = shift_tx_q;
    shift_rx_d = shift_rx_q;
    cnt_d      = cnt_q;
    sdo_d      = sdo_q;
    ctrl_d     = ctrl_q;
    ch_d       = ch_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    bank_d     = bank_q;

    // Bank writes land on bank_d, so a LOAD in the same clk still reads the old entry.
    if (ch_we_in) begin
      bank_d[ch_addr_in] = ch_data_in;
    end

    case (state_q)
      ST_IDLE: begin
        if (conv_fall) begin
          state_d = ST_LOAD;
        end
      end

      ST_LOAD: begin
        shift_tx_d = {{(W_LENGTH-12){1'b0}}, sample};
        cnt_d      = '0;
        sdo_d      = 1'b0;
        state_d    = ST_SHIFT;
      end

      ST_SHIFT: begin
        if (conv_fall) begin
          err_d   = 1'b1;
          state_d = ST_LOAD;
        end else if (conv_rise) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else if (sclk_rise) begin
          shift_rx_d = rx_next;
          cnt_d      = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(W_LENGTH - 1)) begin
            ctrl_d  = rx_next;
            ch_d    = rx_next[7:5];
            done_d  = 1'b1;
            state_d = ST_DONE;
          end
        end else if (sclk_fall) begin
          sdo_d      = shift_tx_q[W_LENGTH-2];
          shift_tx_d = {shift_tx_q[W_LENGTH-2:0], 1'b0};
        end
      end

      ST_DONE: begin
        if (conv_fall) begin
          state_d = ST_LOAD;
        end else if (conv_rise) begin
          state_d = ST_IDLE;
        end else if (sclk_fall) begin
          sdo_d = 1'b0;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      sync_q     <= {SYNC_STAGES{SYNC_RST}};
      prev_q     <= SYNC_RST;
      shift_tx_q <= '0;
      shift_rx_q <= '0;
      cnt_q      <= '0;
      sdo_q      <= 1'b0;
      ctrl_q     <= '0;
      ch_q       <= CH_RST;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      bank_q     <= '0;
    end else begin
      state_q    <= state_d;
      sync_q     <= sync_d;
      prev_q     <= prev_d;
      shift_tx_q <= shift_tx_d;
      shift_rx_q <= shift_rx_d;
      cnt_q      <= cnt_d;
      sdo_q      <= sdo_d;
      ctrl_q     <= ctrl_d;
      ch_q       <= ch_d;
      done_q     <= done_d;
      err_q      <= err_d;
      bank_q     <= bank_d;
    end
  end

  assign sdo_out    = sdo_q;
  assign ctrl_out   = ctrl_q;
  assign ch_out     = ch_q;
  assign frame_done = done_q;
  assign frame_err  = err_q;

endmodule

`default_nettype wire

// File: tb/tb_adc_spi_responder.sv
// +--------------------------------------------------------------------------+
// | tb_adc_spi_responder                                                     |
// | Directed self-checking bench acting as the SPI controller.               |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_adc_spi_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        conv_in = 1'b1;
  logic        sclk_in = 1'b0;
  logic        sdi_in = 1'b0;
  logic        sdo_out;
  logic [2:0]  ch_addr_in = '0;
  logic [11:0] ch_data_in = '0;
  logic        ch_we_in = 1'b0;
  logic [12:0] ctrl_out;
  logic [2:0]  ch_out;
  logic        frame_done;
  logic        frame_err;

  int checks = 0;
  int passed = 0;
  int done_cnt = 0;
  int err_cnt = 0;

  adc_spi_responder #(
    .W_LENGTH   (13),
    .SYNC_STAGES(2),
    .CH_RST     (3'd0)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .conv_in   (conv_in),
    .sclk_in   (sclk_in),
    .sdi_in    (sdi_in),
    .sdo_out   (sdo_out),
    .ch_addr_in(ch_addr_in),
    .ch_data_in(ch_data_in),
    .ch_we_in  (ch_we_in),
    .ctrl_out  (ctrl_out),
    .ch_out    (ch_out),
    .frame_done(frame_done),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_done) done_cnt++;
    if (frame_err)  err_cnt++;
  end

  task automatic bank_write(input logic [2:0] a, input logic [11:0] d);
    @(negedge clk);
    ch_addr_in = a;
    ch_data_in = d;
    ch_we_in   = 1'b1;
    @(negedge clk);
    ch_we_in   = 1'b0;
  endtask

  // Controller model: sdo is captured just before each sclk rise.
  // With coll set, a bank write is issued on the responder's LOAD clk.
  task automatic run_frame(input logic [12:0] cw, input int nbits, input bit coll,
                           input logic [2:0] coll_a, input logic [11:0] coll_d,
                           output logic [15:0] rx);
    rx = '0;
    @(negedge clk);
    conv_in = 1'b0;
    repeat (3) @(negedge clk);
    if (coll) begin
      ch_addr_in = coll_a;
      ch_data_in = coll_d;
      ch_we_in   = 1'b1;
    end
    @(negedge clk);
    ch_we_in = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      sdi_in = (i < 13) ? cw[12-i] : 1'b0;
      repeat (5) @(negedge clk);
      rx = {rx[14:0], sdo_out};
      sclk_in = 1'b1;
      repeat (5) @(negedge clk);
      sclk_in = 1'b0;
    end
    repeat (5) @(negedge clk);
    conv_in = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if ({sdo_out, ctrl_out, ch_out, frame_done, frame_err} !== {1'b0, 13'h0, 3'd0, 1'b0, 1'b0})
      $display("FAIL reset: got sdo=%b ctrl=%h ch=%0d done=%b err=%b required all zero",
               sdo_out, ctrl_out, ch_out, frame_done, frame_err);
    else passed++;
    rst = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_basic;
    logic [15:0] rx;
    int d0, e0;
    bank_write(3'd3, 12'hABC);
    run_frame(13'h0668, 13, 1'b0, 3'd0, 12'h0, rx);
    checks++;
    if (rx[12:0] !== 13'h0000) $display("FAIL basic_first_data: got %h required %h", rx[12:0], 13'h0000);
    else passed++;
    checks++;
    if (ch_out !== 3'd3) $display("FAIL basic_ch_set: got %0d required 3", ch_out);
    else passed++;
    d0 = done_cnt; e0 = err_cnt;
    run_frame(13'h0668, 13, 1'b0, 3'd0, 12'h0, rx);
    checks++;
    if (rx[12:0] !== 13'h0ABC) $display("FAIL basic_stream: got %h required %h", rx[12:0], 13'h0ABC);
    else passed++;
    checks++;
    if (done_cnt - d0 !== 1) $display("FAIL basic_done_pulses: got %0d required 1", done_cnt - d0);
    else passed++;
    checks++;
    if (err_cnt - e0 !== 0) $display("FAIL basic_err_pulses: got %0d required 0", err_cnt - e0);
    else passed++;
    checks++;
    if (ctrl_out !== 13'h0668 || ch_out !== 3'd3)
      $display("FAIL basic_ctrl: got ctrl=%h ch=%0d required ctrl=0668 ch=3", ctrl_out, ch_out);
    else passed++;
  endtask

  task automatic test_pipeline;
    logic [15:0] rx;
    run_frame(13'h0008, 13, 1'b0, 3'd0, 12'h0, rx);
    bank_write(3'd0, 12'h00F);
    bank_write(3'd5, 12'h123);
    checks++;
    if (ch_out !== 3'd0) $display("FAIL pipe_ch0: got %0d required 0", ch_out);
    else passed++;
    run_frame(13'h00A0, 13, 1'b0, 3'd0, 12'h0, rx);
    checks++;
    if (rx[12:0] !== 13'h000F) $display("FAIL pipe_frame1: got %h required %h", rx[12:0], 13'h000F);
    else passed++;
    run_frame(13'h00A0, 13, 1'b0, 3'd0, 12'h0, rx);
    checks++;
    if (rx[12:0] !== 13'h0123) $display("FAIL pipe_frame2: got %h required %h", rx[12:0], 13'h0123);
    else passed++;
  endtask

  task automatic test_abort;
    logic [15:0] rx;
    int d0, e0;
    d0 = done_cnt; e0 = err_cnt;
    run_frame(13'h1FE0, 7, 1'b0, 3'd0, 12'h0, rx);
    checks++;
    if (err_cnt - e0 !== 1 || done_cnt - d0 !== 0)
      $display("FAIL abort_pulses: got err=%0d done=%0d required err=1 done=0", err_cnt - e0, done_cnt - d0);
    else passed++;
    checks++;
    if (ctrl_out !== 13'h00A0 || ch_out !== 3'd5)
      $display("FAIL abort_hold: got ctrl=%h ch=%0d required ctrl=00a0 ch=5", ctrl_out, ch_out);
    else passed++;
    d0 = done_cnt;
    run_frame(13'h0068, 13, 1'b0, 3'd0, 12'h0, rx);
    checks++;
    if (rx[12:0] !== 13'h0123 || done_cnt - d0 !== 1 || ctrl_out !== 13'h0068)
      $display("FAIL abort_recover: got data=%h done=%0d ctrl=%h required 0123 1 0068",
               rx[12:0], done_cnt - d0, ctrl_out);
    else passed++;
  endtask

  task automatic test_overclock;
    logic [15:0] rx;
    run_frame(13'h0048, 16, 1'b0, 3'd0, 12'h0, rx);
    checks++;
    if (rx !== 16'h55E0) $display("FAIL overclock_stream: got %h required %h", rx, 16'h55E0);
    else passed++;
    checks++;
    if (ctrl_out !== 13'h0048 || ch_out !== 3'd2)
      $display("FAIL overclock_ctrl: got ctrl=%h ch=%0d required ctrl=0048 ch=2", ctrl_out, ch_out);
    else passed++;
  endtask

  task automatic test_collision;
    logic [15:0] rx;
    bank_write(3'd2, 12'h5A5);
    run_frame(13'h0048, 13, 1'b1, 3'd2, 12'hFFF, rx);
    checks++;
    if (rx[12:0] !== 13'h05A5) $display("FAIL collision_old: got %h required %h", rx[12:0], 13'h05A5);
    else passed++;
    run_frame(13'h0048, 13, 1'b0, 3'd0, 12'h0, rx);
    checks++;
    if (rx[12:0] !== 13'h0FFF) $display("FAIL collision_new: got %h required %h", rx[12:0], 13'h0FFF);
    else passed++;
  endtask

  task automatic test_pattern;
    logic [15:0] rx;
    logic [12:0] exp;
    bank_write(3'd6, 12'h321);
    run_frame(13'h10C0, 13, 1'b0, 3'd0, 12'h0, rx);
    checks++;
    if (ctrl_out !== 13'h10C0 || ch_out !== 3'd6)
      $display("FAIL pattern_ctrl: got ctrl=%h ch=%0d required ctrl=10c0 ch=6", ctrl_out, ch_out);
    else passed++;
    run_frame(13'h00C0, 13, 1'b0, 3'd0, 12'h0, rx);
`ifdef ADC_RESP_TESTPAT_EN
    exp = 13'h0CA5;
`else
    exp = 13'h0321;
`endif
    checks++;
    if (rx[12:0] !== exp) $display("FAIL pattern_data: got %h required %h", rx[12:0], exp);
    else passed++;
    run_frame(13'h00C0, 13, 1'b0, 3'd0, 12'h0, rx);
    checks++;
    if (rx[12:0] !== 13'h0321) $display("FAIL pattern_after: got %h required %h", rx[12:0], 13'h0321);
    else passed++;
  endtask

  task automatic test_reset_midframe;
    int e0;
    e0 = err_cnt;
    @(negedge clk);
    conv_in = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      sdi_in = 1'b1;
      repeat (5) @(negedge clk);
      sclk_in = 1'b1;
      repeat (5) @(negedge clk);
      sclk_in = 1'b0;
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (err_cnt - e0 !== 0 || ctrl_out !== 13'h0 || ch_out !== 3'd0 || sdo_out !== 1'b0)
      $display("FAIL reset_midframe: got err=%0d ctrl=%h ch=%0d sdo=%b required 0 0000 0 0",
               err_cnt - e0, ctrl_out, ch_out, sdo_out);
    else passed++;
    conv_in = 1'b1;
    sdi_in  = 1'b0;
    rst     = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_pipeline();
    test_abort();
    test_overclock();
    test_collision();
    test_pattern();
    test_reset_midframe();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/adc_spi_responder.md
Name: adc_spi_responder

Overview:
- SPI responder that emulates the 8-channel, 12-bit serial ADC on the FPGA side of the existing ADC SPI controller.
- Used for loopback and board bring-up with no physical ADC fitted.
- Decodes the 13-bit control word the controller sends, tracks the selected channel, and returns that channel's 12-bit sample on sdo.
- Sample values come from a host-writable 8-entry register bank.

Parameters:
- W_LENGTH, 13, bits per SPI frame (fixed frame format below; other values unsupported).
- SYNC_STAGES, 2, flip-flop stages on conv_in/sclk_in/sdi_in, 2..3.
- CH_RST, 0, channel used for the first conversion after reset.

Ports:
- clk  in  1  system clock; must be ≥8x sclk_in frequency.
- rst  in  1  synchronous reset, active-low.
- conv_in  in  1  conversion strobe; a high-to-low edge starts a conversion, low marks the frame window.
- sclk_in  in  1  serial clock from the controller, idle low.
- sdi_in  in  1  serial data from the controller, MSB first.
- sdo_out  out  1  serial data to the controller, MSB first.
- ch_addr_in  in  3  sample-bank write address.
- ch_data_in  in  12  sample-bank write data.
- ch_we_in  in  1  sample-bank write enable, one clk.
- ctrl_out  out  13  last complete control word received.
- ch_out  out  3  channel currently being converted.
- frame_done  out  1  one-clk pulse when a full frame completes.
- frame_err  out  1  one-clk pulse when a frame is aborted short.

Behaviour:
- Reset (rst low at a clk edge):
  - sdo_out=0, ctrl_out=0, ch_out=CH_RST, frame_done=0, frame_err=0.
  - Sample bank cleared to 0, bit counter=0, FSM=IDLE.
- Input synchronisation: all three inputs pass through SYNC_STAGES flops. Edges are detected on the synchronised copies, so latency is SYNC_STAGES+1 clk.
- Control word bit map, [12:0] in arrival order:
  - [12] A0, [11:10] PD1:PD0, [9] VIN8, [8] DIFF, [7:5] CH2:CH0, [4] nCONVS, [3] EXT_REF, [2:0] zero.
- Frame format on sdo: bit 12 = 0, then D11..D0.
- FSM states:
  - IDLE: wait for conv falling edge.
  - LOAD: one clk. shift_tx <= {1'b0, bank[ch_out]}; bit counter=0; sdo_out <= shift_tx[12]. Go to SHIFT.
  - SHIFT:
    - On each sclk rising edge: shift_rx <= {shift_rx[11:0], sdi}, counter++.
    - On each sclk falling edge: shift_tx shifts left and sdo_out presents the next bit.
    - When counter reaches 13, go to DONE.
    - conv rising edge with counter<13 → frame_err pulse, go to IDLE; ctrl_out and ch_out unchanged.
  - DONE:
    - Entered on the clk after the 13th rising edge.
    - ctrl_out <= shift_rx; ch_out <= shift_rx[7:5]; frame_done pulses.
    - The new channel takes effect on the next conversion (pipelined, matching the real ADC).
    - Extra sclk edges: ignored, sdo_out=0.
    - Stay until the conv rising edge, then go to IDLE.
- Conv falling edge while in SHIFT or DONE (glitch): treat as abort plus restart. frame_err pulses only if in SHIFT. Then go to LOAD.
- Simultaneous sclk edge and conv rising edge in SHIFT: the conv edge wins; the bit is dropped.
- Bank write: ch_we_in writes bank[ch_addr_in] on the same clk in any state. A write to the channel being loaded in LOAD returns the old value (read before write).
- sdo_out changes only in LOAD or on sclk falling edges; it is held otherwise.
- rst low mid-frame aborts immediately with no frame_err pulse.

Optional Feature:
- Macro: ADC_RESP_TESTPAT_EN.
- Defined: if the latched ctrl_out[12] (A0)=1, the next LOAD uses pattern {ch_out, 9'h0A5} instead of the bank value.
- Undefined: A0 is stored in ctrl_out only and has no effect on data.

Test Plan:
- Reset then bank[3]=12'hABC, ch_out=3; conv low, send 13 sclk with control word 13'h0668 → sdo stream 0,1010_1011_1100; frame_done once; ctrl_out=13'h0668; ch_out=3.
- Channel pipeline: frame1 sends CH=5 with bank[5]=12'h123, ch_out=0, bank[0]=12'h00F → frame1 returns 12'h00F, frame2 returns 12'h123.
- Abort: conv rises after 7 sclk → frame_err pulse, no frame_done, ctrl_out unchanged; the next full frame completes normally.
- Over-clock: 16 sclk in one frame → bits 14-16 of sdo read 0; ctrl_out holds the first 13 bits.
- Write collision: ch_we_in to bank[ch_out] on the LOAD clk with 12'hFFF → current frame returns the old value, next frame returns 12'hFFF.
- Test pattern (macro defined): A0=1 in a frame selecting CH=6 → next frame returns {3'd6, 9'h0A5}=12'hCA5. With the macro undefined → the bank value is returned.
